multicycle_mem: RTL and testbench

- Word-organised data/instruction memory that acts as the responder to the CPU's fetch and load/store requests.
- Replaces the single-cycle memory with a fixed-latency model.
- Reads are accepted at one clock edge and return data LATENCY cycles later with a valid strobe and address tag. Writes commit at the accept edge.
- Pipelined by default, so one request can be accepted per cycle. This makes it the backing store that future cache-fill and stall logic will talk to.

---
 rtl/multicycle_mem.sv | 68 ++++++
 tb/tb_multicycle_mem.sv | 138 +++++++++++++
 2 files changed

// File: rtl/multicycle_mem.sv
// multicycle_mem: fixed-latency pipelined word memory with tagged read responses; MCMEM_BLOCKING_EN selects a blocking one-read-in-flight responder
module multicycle_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] data_addr
);
  logic [DATA_WIDTH-1:0] mem [2**(ADDR_WIDTH-1)];
  logic [LATENCY-1:0] pv;
  logic [ADDR_WIDTH-1:0] pa [LATENCY];
  logic [DATA_WIDTH-1:0] pd [LATENCY];
  logic rst_q, rd, wa;
  assign rd = enable & ready & ~wr;
  assign wa = enable & ready & wr;
  always_ff @(posedge clk) rst_q <= rst;
  always_ff @(posedge clk) if (wa) mem[addr[ADDR_WIDTH-1:1]] <= data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pa[i] <= '0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= rd;
      pa[0] <= rd ? (addr & ~ADDR_WIDTH'(1)) : '0;
      pd[0] <= rd ? mem[addr[ADDR_WIDTH-1:1]] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign data_valid = pv[LATENCY-1] & ~rst;
  assign data_out   = rst ? '0 : pd[LATENCY-1];
  assign data_addr  = rst ? '0 : pa[LATENCY-1];
`ifdef MCMEM_BLOCKING_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [2:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (rd) begin
        state <= BUSY;
        cnt   <= 3'(LATENCY-1);
      end
    end else if (cnt == '0) state <= IDLE;
    else cnt <= cnt - 3'd1;
  end
  assign ready = ~rst & ~rst_q & (state == IDLE);
`else
  assign ready = ~rst & ~rst_q;
`endif
endmodule

// File: tb/tb_multicycle_mem.sv
// tb_multicycle_mem: directed table plus randomized traffic against a queue-based memory model
module tb_multicycle_mem;
  localparam int L = 4;
  logic clk = 0, rst = 0, enable = 0, wr = 0, ready, data_valid;
  logic [15:0] addr = 0, data_in = 0, data_out, data_addr;
  int errs = 0, checks = 0, cyc = 0, busy_until = -1;
  logic rq_m = 0;
  typedef struct {int due; logic [15:0] a, d;} rsp_t;
  rsp_t q[$];
  logic [15:0] mm [bit [14:0]];
  typedef struct {logic r, e, w; logic [15:0] a, d; logic xr, xv; logic [15:0] xd, xa;} vec_t;
  vec_t tv[$];
  logic o_r, o_v;
  logic [15:0] o_d, o_a;

  multicycle_mem #(.ADDR_WIDTH(16), .LATENCY(L), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .ready(ready), .data_out(data_out), .data_valid(data_valid), .data_addr(data_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %h expected %h", n, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic er, ev;
    logic [15:0] ed, ea;
    rst = r; enable = e; wr = w; addr = a; data_in = d;
    er = !r && !rq_m;
`ifdef MCMEM_BLOCKING_EN
    er = er && (cyc > busy_until);
`endif
    #1;
    o_r = ready;
    chk("ready", cyc, {15'd0, ready}, {15'd0, er});
    if (r) chk("valid_in_rst", cyc, {15'd0, data_valid}, 16'd0);
    @(posedge clk);
    cyc++;
    if (e && er) begin
      if (w) mm[a[15:1]] = d;
      else begin
        q.push_back('{cyc + L - 1, {a[15:1], 1'b0}, mm[a[15:1]]});
        busy_until = cyc + L - 1;
      end
    end
    if (r) begin
      q.delete();
      busy_until = -1;
    end
    rq_m = r;
    @(negedge clk);
    ev = 0; ed = 0; ea = 0;
    if (q.size() != 0 && q[0].due == cyc) begin
      ev = 1; ed = q[0].d; ea = q[0].a;
      void'(q.pop_front());
    end
    o_v = data_valid; o_d = data_out; o_a = data_addr;
    chk("valid", cyc, {15'd0, data_valid}, {15'd0, ev});
    chk("data", cyc, data_out, ed);
    chk("addr", cyc, data_addr, ea);
  endtask

  function automatic void add(input logic r, e, w, input logic [15:0] a, d, input logic xr, xv, input logic [15:0] xd, xa);
    tv.push_back('{r, e, w, a, d, xr, xv, xd, xa});
  endfunction

  initial begin
    add(1,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
    add(0,1,1,16'h0010,16'hBEEF, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0010,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,1,16'hBEEF,16'h0010);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,1,16'h0020,16'h1111, 1,0,16'h0000,16'h0000);
    add(0,1,1,16'h0022,16'h2222, 1,0,16'h0000,16'h0000);
    add(0,1,1,16'h0024,16'h3333, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0020,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0022,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0024,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,1,16'h1111,16'h0020);
    add(0,0,0,16'h0000,16'h0000, 1,1,16'h2222,16'h0022);
    add(0,0,0,16'h0000,16'h0000, 1,1,16'h3333,16'h0024);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,1,16'h0030,16'hAAAA, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0030,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,1,16'h0030,16'h5555, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0030,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,1,16'hAAAA,16'h0030);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,1,16'h5555,16'h0030);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,1,16'h0050,16'h7777, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0051,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,1,16'h7777,16'h0050);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,1,16'h0040,16'h4040, 1,0,16'h0000,16'h0000);
    add(0,1,1,16'h0042,16'h4242, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0040,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0042,16'h0000, 1,0,16'h0000,16'h0000);
    add(1,1,1,16'h0040,16'hDEAD, 0,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,1,0,16'h0040,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    add(0,0,0,16'h0000,16'h0000, 1,1,16'h4040,16'h0040);
    add(0,0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].e, tv[i].w, tv[i].a, tv[i].d);
`ifndef MCMEM_BLOCKING_EN
      chk("tbl_ready", i, {15'd0, o_r}, {15'd0, tv[i].xr});
      chk("tbl_valid", i, {15'd0, o_v}, {15'd0, tv[i].xv});
      chk("tbl_data", i, o_d, tv[i].xd);
      chk("tbl_addr", i, o_a, tv[i].xa);
`endif
    end
    step(1, 0, 0, 16'h0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 128; i++) step(0, 1, 1, 16'(2 * i), 16'($urandom));
    for (int i = 0; i < 600; i++)
      step($urandom_range(39) == 0, $urandom_range(3) != 0, $urandom_range(2) == 0,
           16'($urandom_range(255)), 16'($urandom));
    for (int i = 0; i < L + 2; i++) step(0, 0, 0, 16'h0, 16'h0);
    chk("drained", cyc, 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
